// File: rtl/bldc_deadtime_gate_pkg.sv
// Shared types for the BLDC gate-drive stage: half-bridge state encoding and defaults.
package bldc_deadtime_gate_pkg;

    typedef enum logic [1:0] {
        HB_OFF  = 2'd0,
        HB_HI   = 2'd1,
        HB_LO   = 2'd2,
        HB_DEAD = 2'd3
    } halfbridge_state_t;

    localparam int BLDC_DEAD_CYCLES_DEFAULT = 8;
    localparam int BLDC_PHASES              = 3;

endpackage

// File: rtl/bldc_deadtime_gate_if.sv
// Request/gate bundle between the commutation table side and the gate-drive stage.
interface bldc_deadtime_gate_if;
    logic       en;
    logic       pwm;
    logic [5:0] phase_enable;
    logic       table_error;
    logic       fault_clr;
    logic [5:0] gate;
    logic       fault;
    logic       busy;

    modport master (
        output en, pwm, phase_enable, table_error, fault_clr,
        input  gate, fault, busy
    );

    modport slave (
        input  en, pwm, phase_enable, table_error, fault_clr,
        output gate, fault, busy
    );
endinterface

// File: rtl/bldc_deadtime_gate_chk.sv
// Shoot-through checker: the high and low gate of one phase are never on together.
module bldc_deadtime_gate_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [5:0] gate
);

    a_no_shoot_through: assert property (
        @(posedge clk) disable iff (!rst_n) ((gate[5:3] & gate[2:0]) == 3'b000)
    );

endmodule

// File: rtl/bldc_halfbridge_deadtime.sv
// One half-bridge: OFF/HI/LO/DEAD sequencer guaranteeing DEAD_CYCLES of both-off
// between any on state and any other state.
module bldc_halfbridge_deadtime
    import bldc_deadtime_gate_pkg::*;
#(
    parameter int DEAD_CYCLES = BLDC_DEAD_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_hi,
    input  logic req_lo,
    output logic gate_hi,
    output logic gate_lo,
    output logic in_dead
);

    localparam int              CNT_W    = $clog2(DEAD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    halfbridge_state_t state_r, state_s, req_state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              gate_hi_r, gate_lo_r, in_dead_r;

    // Next-state: requests are only acted on from OFF, HI, LO, or at dead-time expiry
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        if (req_hi) begin
            req_state_s = HB_HI;
        end else if (req_lo) begin
            req_state_s = HB_LO;
        end else begin
            req_state_s = HB_OFF;
        end
        case (state_r)
            HB_OFF: begin
                state_s = req_state_s;
            end
            HB_HI, HB_LO: begin
                if (req_state_s != state_r) begin
                    state_s = HB_DEAD;
                    cnt_s   = CNT_LOAD;
                end else begin
                    state_s = state_r;
                end
            end
            HB_DEAD: begin
                if (cnt_r == CNT_ONE) begin
                    state_s = req_state_s;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = HB_DEAD;
                cnt_s   = CNT_LOAD;
            end
        endcase
    end

    // State register; gate pins are flopped from the next state so they never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= HB_DEAD;
            cnt_r     <= CNT_LOAD;
            gate_hi_r <= 1'b0;
            gate_lo_r <= 1'b0;
            in_dead_r <= 1'b1;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            gate_hi_r <= (state_s == HB_HI);
            gate_lo_r <= (state_s == HB_LO);
            in_dead_r <= (state_s == HB_DEAD);
        end
    end

    assign gate_hi = gate_hi_r;
    assign gate_lo = gate_lo_r;
    assign in_dead = in_dead_r;

endmodule

// File: rtl/bldc_deadtime_gate.sv
// BLDC gate-drive stage: PWM chop, shoot-through/table fault latch, and three
// independent dead-time half-bridges driving the gate pins.
module bldc_deadtime_gate
    import bldc_deadtime_gate_pkg::*;
#(
    parameter int DEAD_CYCLES = BLDC_DEAD_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bldc_deadtime_gate_if.slave   bus
);

    logic [2:0] hi_s, lo_s, conflict_s, req_hi_s, req_lo_s;
    logic [2:0] gate_hi_s, gate_lo_s, in_dead_s;
    logic       set_s, fault_next_s, fault_r;

    assign hi_s = bus.phase_enable[5:3];
    assign lo_s = bus.phase_enable[2:0];

    // Fault set wins over clear; requests are masked by the fault value about to be latched
    always_comb begin
        conflict_s   = {3{bus.en}} & hi_s & lo_s;
        set_s        = bus.en & (bus.table_error | (|conflict_s));
        fault_next_s = set_s | (fault_r & ~bus.fault_clr);
        req_hi_s     = {3{bus.en & bus.pwm & ~fault_next_s}} & hi_s;
        req_lo_s     = {3{bus.en & ~fault_next_s}} & lo_s;
    end

    // Sticky fault latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= fault_next_s;
        end
    end

    // Bit 2 is phase A, bit 0 is phase C, matching phase_enable packing
    for (genvar i = 0; i < BLDC_PHASES; i++) begin : g_bridge
        bldc_halfbridge_deadtime #(
            .DEAD_CYCLES (DEAD_CYCLES)
        ) u_hb (
            .clk     (clk),
            .rst_n   (rst_n),
            .req_hi  (req_hi_s[i]),
            .req_lo  (req_lo_s[i]),
            .gate_hi (gate_hi_s[i]),
            .gate_lo (gate_lo_s[i]),
            .in_dead (in_dead_s[i])
        );
    end

    assign bus.gate  = {gate_hi_s, gate_lo_s};
    assign bus.fault = fault_r;
    assign bus.busy  = |in_dead_s;

endmodule

// File: doc/bldc_deadtime_gate.md
# bldc_deadtime_gate

Gate-drive stage directly downstream of the BLDC commutation table. Takes the registered 6-bit phase-enable vector and error flag, chops the high side with an external PWM signal, and enforces a programmable dead time per half-bridge so that the high and low switches of one phase are never on together or switched back-to-back. It latches faults and forces all gates off until the fault is cleared. Its outputs drive the gate-driver pins directly.

## Interface
- DEAD_CYCLES, 8, number of clk cycles both switches of a half-bridge are held off between any on→other transition; legal range ≥1
- CNT_W, $clog2(DEAD_CYCLES+1), dead-time counter width; derived, not overridden
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  drive enable; 0 treats all requests as OFF (not a fault)
- pwm  in  1  PWM chop signal, synchronous to clk; ANDed into high-side requests
- phase_enable  in  6  from commutation table, {hi_A,hi_B,hi_C,lo_A,lo_B,lo_C}
- table_error  in  1  error flag from commutation table
- fault_clr  in  1  single-cycle request to clear the latched fault
- gate  out  6  gate drive, same bit order as phase_enable
- fault  out  1  sticky fault flag
- busy  out  1  1 while any half-bridge is in DEAD

## Operation
- Per phase x: req_hi = en & pwm & hi_x & ~fault_next; req_lo = en & lo_x & ~fault_next; the request is HI, LO, or OFF.
- Conflict: en & hi_x & lo_x for any x is a shoot-through request. It sets fault independent of pwm.
- Fault set condition: table_error | conflict (any phase), evaluated only when en=1. fault_next = set | (fault & ~fault_clr). Set wins over a simultaneous fault_clr.
- Half-bridge FSM states: OFF, HI, LO, DEAD. Outputs are decoded from the registered state: hi=1 only in HI, lo=1 only in LO.
- OFF: request HI→HI, request LO→LO, otherwise stay in OFF.
- HI: request HI→stay; any other request→DEAD with counter loaded to DEAD_CYCLES. LO behaves symmetrically.
- DEAD: counter decrements each cycle. When the counter is 1, the next state follows the current request (HI/LO/OFF). The request is re-evaluated only at expiry.
- A request that returns to the original side during DEAD still completes the full dead time.
- PWM low during HI is a request change, so every PWM falling edge on the high side passes through DEAD before any low-side turn-on.
- While fault=1, all requests are OFF. Active bridges enter DEAD, then OFF. Gates stay off until fault is cleared, after which normal operation resumes.
- busy = OR of (state==DEAD) over the three bridges.

## Timing
- Reset (async assert): gate=0, fault=0. All FSMs enter DEAD with counter=DEAD_CYCLES, so busy=1. After rst_n deasserts, gates stay off for DEAD_CYCLES cycles.
- OFF→on latency: request present at edge n, gate bit high after edge n+1.
- On→opposite side: request change at edge n, active gate low after edge n+1, opposite gate high after edge n+1+DEAD_CYCLES. Both gates are low for exactly DEAD_CYCLES cycles.
- On→OFF: gate low after edge n+1. The bridge stays in DEAD for DEAD_CYCLES cycles before reaching OFF.
- Fault: set condition at edge n, fault=1 and all gates low after edge n+1.
- fault_clr at edge m with no set condition: fault=0 after edge m+1. Requests are honoured from edge m+1, still subject to any remaining DEAD.
- Phases are fully independent. Simultaneous transitions on several phases each get their own dead time.
- Invariant, checked by assertion: gate[5-x] & gate[2-x] is never 1.

## Structure
- Add to the shared types package: halfbridge_state_t {HB_OFF, HB_HI, HB_LO, HB_DEAD} and a default constant BLDC_DEAD_CYCLES_DEFAULT.
- Sub-module bldc_halfbridge_deadtime:
  - inputs clk, rst_n, req_hi, req_lo; outputs gate_hi, gate_lo, in_dead; parameter DEAD_CYCLES.
  - instantiated three times.
- The top level holds only request decode, fault latch, and output packing.

## Test plan
- DEAD_CYCLES=4, reset released, en=1, pwm=1, phase_enable=6'b100010 (A hi, B lo) → gates 0 for 4 cycles after release, then gate=6'b100010.
- From A-hi/B-lo steady, switch to 6'b010100 (B hi, A lo) → hi_A and lo_B low after 1 cycle. Exactly 4 cycles with gate=0, then gate=6'b010100.
- pwm toggles 1/0 every 10 cycles with phase_enable=6'b100010 → hi_A follows pwm with a 1-cycle delay. Each off period enters DEAD, busy=1 for 4 cycles, and lo_B stays 1 throughout.
- phase_enable=6'b100100 (A hi and A lo) → fault=1 and gate=0 next cycle. fault stays 1 after the input is corrected. fault_clr pulse → fault=0, then drive resumes.
- table_error=1 asserted together with fault_clr → fault remains 1 and all gates low.
- rst_n pulsed low for 1 cycle mid-drive → gate=0 immediately (asynchronous). After release, gate=0 and busy=1 for 4 cycles before the gates re-enable.
